// File: rtl/host_mem_loader.sv
// Packs an incoming byte stream into masked 64-bit memory host writes, wrapping modulo NUM_BYTES.
// Define HOST_MEM_LOADER_VERIFY_EN to add a readback checksum pass (VERIFY state) after the load.
module host_mem_loader #(
    parameter int NUM_BYTES  = 2097152,
    parameter int DATA_WIDTH = 64,
    localparam int ADDR_WIDTH = $clog2(NUM_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic [ADDR_WIDTH-1:0] hw_addr,
    output logic [DATA_WIDTH-1:0] hw_data,
    output logic [7:0]            hw_mask,
    output logic                  hw_en,
    output logic [ADDR_WIDTH-1:0] hr_addr,
    input  logic [DATA_WIDTH-1:0] hr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic                  verify_err
);

    // Handshake: a byte transfers on every rising edge where in_valid && in_ready;
    // in_ready is a function of state only (high exactly in LOAD), never of in_valid.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLUSH  = 3'd2,
        S_VERIFY = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BYTES - 1);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_next;
    logic [DATA_WIDTH-1:0] acc_data_q;
    logic [DATA_WIDTH-1:0] merged_data;
    logic [7:0]            acc_mask_q;
    logic [7:0]            merged_mask;
    logic [2:0]            lane;
    logic                  accept;
    logic                  close_word;
    logic                  start_ok;
    logic                  rd_last;
    logic                  unused_hr;

    assign lane        = ptr_q[2:0];
    assign accept      = in_valid && in_ready;
    assign close_word  = accept && ((lane == 3'd7) || in_last);
    assign start_ok    = (state_q == S_IDLE) && start;
    assign ptr_next    = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_WIDTH'(1);
    assign merged_data = acc_data_q | (DATA_WIDTH'(in_data) << {lane, 3'b000});
    assign merged_mask = acc_mask_q | (8'b1 << lane);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
`ifdef HOST_MEM_LOADER_VERIFY_EN
                state_d = S_VERIFY;
`else
                state_d = S_DONE;
`endif
            end
            S_VERIFY: begin
                if (rd_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The accumulator only ever holds bytes in masked lanes, so unmasked lanes of hw_data stay 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            acc_data_q <= '0;
            acc_mask_q <= '0;
            byte_count <= '0;
            hw_addr    <= '0;
            hw_data    <= '0;
            hw_mask    <= '0;
            hw_en      <= 1'b0;
        end else begin
            hw_en <= 1'b0;
            if (start_ok) begin
                ptr_q      <= base_addr;
                byte_count <= '0;
                acc_data_q <= '0;
                acc_mask_q <= '0;
            end
            if (accept) begin
                ptr_q      <= ptr_next;
                byte_count <= byte_count + (ADDR_WIDTH + 1)'(1);
                if (close_word) begin
                    hw_addr    <= {ptr_q[ADDR_WIDTH-1:3], 3'b000};
                    hw_data    <= merged_data;
                    hw_mask    <= merged_mask;
                    hw_en      <= 1'b1;
                    acc_data_q <= '0;
                    acc_mask_q <= '0;
                end else begin
                    acc_data_q <= merged_data;
                    acc_mask_q <= merged_mask;
                end
            end
        end
    end

`ifdef HOST_MEM_LOADER_VERIFY_EN
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   rd_cnt_q;
    logic [15:0]           checksum_q;
    logic [15:0]           rd_sum_q;
    logic [15:0]           rd_sum_next;

    assign rd_last     = (rd_cnt_q == byte_count - (ADDR_WIDTH + 1)'(1));
    assign rd_sum_next = rd_sum_q + {8'h00, hr_data[7:0]};
    assign hr_addr     = (state_q == S_VERIFY) ? rd_ptr_q : '0;
    assign unused_hr   = ^hr_data[DATA_WIDTH-1:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q     <= '0;
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            checksum_q <= '0;
            rd_sum_q   <= '0;
            verify_err <= 1'b0;
        end else begin
            if (start_ok) begin
                base_q     <= base_addr;
                checksum_q <= '0;
                verify_err <= 1'b0;
            end
            if (accept) begin
                checksum_q <= checksum_q + {8'h00, in_data};
            end
            if (state_q == S_FLUSH) begin
                rd_ptr_q <= base_q;
                rd_cnt_q <= '0;
                rd_sum_q <= '0;
            end
            // The comparison lands on the edge into DONE so verify_err is valid with the done pulse.
            if (state_q == S_VERIFY) begin
                rd_ptr_q <= (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
                rd_cnt_q <= rd_cnt_q + (ADDR_WIDTH + 1)'(1);
                rd_sum_q <= rd_sum_next;
                if (rd_last) begin
                    verify_err <= (rd_sum_next != checksum_q);
                end
            end
        end
    end
`else
    assign rd_last    = 1'b0;
    assign hr_addr    = '0;
    assign verify_err = 1'b0;
    assign unused_hr  = ^hr_data;
`endif

endmodule

// File: tb/tb_host_mem_loader.sv
// Directed self-checking bench for host_mem_loader: word packing, masks, wrap, stalls-free streaming, reset.
module tb_host_mem_loader;

    localparam int AW = 21;
    localparam int W  = AW + 8 + 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = '0;
    logic          in_last = 1'b0;
    logic [AW-1:0] hw_addr;
    logic [63:0]   hw_data;
    logic [7:0]    hw_mask;
    logic          hw_en;
    logic [AW-1:0] hr_addr;
    logic [63:0]   hr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   byte_count;
    logic          verify_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int not_ready = 0;
    int lat = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_cyc[$];

    logic [7:0]    mem [0:4095];
    logic          corrupt = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    host_mem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .hw_addr    (hw_addr),
        .hw_data    (hw_data),
        .hw_mask    (hw_mask),
        .hw_en      (hw_en),
        .hr_addr    (hr_addr),
        .hr_data    (hr_data),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count),
        .verify_err (verify_err)
    );

    // clock / reset and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory model: byte-lane writes, byte read returned in lane 0
    always @(posedge clk) begin
        if (hw_en) begin
            for (int l = 0; l < 8; l++) begin
                if (hw_mask[l]) mem[12'(hw_addr + AW'(l))] <= hw_data[8*l +: 8];
            end
        end
    end

    always_comb begin
        hr_data = {56'h0, mem[hr_addr[11:0]]};
        if (corrupt && hr_addr == corrupt_addr) hr_data[7:0] = hr_data[7:0] ^ 8'h5A;
    end

    // write monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (hw_en) begin
            got_q.push_back({hw_addr, hw_mask, hw_data});
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [AW-1:0] base);
        start = 1'b1;
        base_addr = base;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int n, input logic [7:0] first, input logic [7:0] step, input logic last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = first + 8'(i) * step;
            in_last = last && (i == n - 1);
            if (!in_ready) not_ready++;
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        lat = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [7:0] m, input logic [63:0] d);
        exp_q.push_back({a, m, d});
    endtask

    task automatic compare_writes(input string tag);
        logic [W-1:0] g;
        logic [W-1:0] e;
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_addr"}, 64'(g[W-1:72]), 64'(e[W-1:72]));
            check({tag, "_mask"}, 64'(g[71:64]), 64'(e[71:64]));
            check({tag, "_data"}, g[63:0], e[63:0]);
        end
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 0);
        check({tag, "_hw_en"}, 64'(hw_en), 0);
        check({tag, "_hw_mask"}, 64'(hw_mask), 0);
        check({tag, "_hw_addr"}, 64'(hw_addr), 0);
        check({tag, "_hw_data"}, hw_data, 0);
        check({tag, "_hr_addr"}, 64'(hr_addr), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_byte_count"}, 64'(byte_count), 0);
        check({tag, "_verify_err"}, 64'(verify_err), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // aligned full word, 01..08
        start_load(21'h100);
        check("t1_busy", 64'(busy), 1);
        check("t1_in_ready", 64'(in_ready), 1);
        send(8, 8'h01, 8'h01, 1'b1);
        check("t1_flush_hw_en", 64'(hw_en), 1);
`ifndef HOST_MEM_LOADER_VERIFY_EN
        check("t1_not_done_in_flush", 64'(done), 0);
        tick();
        check("t1_done_after_flush", 64'(done), 1);
        check("t1_hw_en_single", 64'(hw_en), 0);
`else
        wait_done("t1");
`endif
        check("t1_byte_count", 64'(byte_count), 8);
        tick();
        check("t1_idle_busy", 64'(busy), 0);
        check("t1_idle_done", 64'(done), 0);
        expect_write(21'h100, 8'hFF, 64'h0807060504030201);
        compare_writes("t1");

        // unaligned partial word; start while busy is ignored
        start_load(21'h103);
        start = 1'b1;
        base_addr = 21'h500;
        tick();
        start = 1'b0;
        send(3, 8'hAA, 8'h11, 1'b1);
        wait_done("t2");
        check("t2_byte_count", 64'(byte_count), 3);
        tick();
        expect_write(21'h100, 8'h38, 64'h0000CCBBAA000000);
        compare_writes("t2");

        // in_valid outside LOAD is ignored; byte_count holds after DONE
        in_valid = 1'b1;
        in_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            if (in_ready) not_ready++;
            tick();
        end
        in_valid = 1'b0;
        check("t2_idle_ready_seen", 64'(not_ready), 0);
        check("t2_byte_count_hold", 64'(byte_count), 3);
        compare_writes("t2_idle");

        // wrap across the top of memory
        start_load(21'h1FFFFE);
        send(4, 8'h11, 8'h11, 1'b1);
        wait_done("t3");
        check("t3_byte_count", 64'(byte_count), 4);
        tick();
        expect_write(21'h1FFFF8, 8'hC0, 64'h2211000000000000);
        expect_write(21'h000000, 8'h03, 64'h0000000000004433);
        compare_writes("t3");

        // 16 bytes at full rate: no bubbles, two writes 8 cycles apart
        not_ready = 0;
        start_load(21'h0);
        send(16, 8'h01, 8'h01, 1'b1);
        wait_done("t4");
        tick();
        check("t4_not_ready", 64'(not_ready), 0);
        check("t4_spacing", 64'(got_cyc.size() == 2 ? got_cyc[1] - got_cyc[0] : 0), 8);
        expect_write(21'h000, 8'hFF, 64'h0807060504030201);
        expect_write(21'h008, 8'hFF, 64'h100F0E0D0C0B0A09);
        compare_writes("t4");

        // reset mid-load discards the partial word
        start_load(21'h200);
        send(5, 8'h01, 8'h01, 1'b0);
        rst_n = 1'b0;
        tick();
        check_all_zero("t5_rst");
        rst_n = 1'b1;
        tick();
        tick();
        compare_writes("t5_rst");
        start_load(21'h40);
        send(2, 8'h05, 8'h01, 1'b1);
        wait_done("t5");
        check("t5_byte_count", 64'(byte_count), 2);
        tick();
        expect_write(21'h040, 8'h03, 64'h0000000000000605);
        compare_writes("t5");

`ifdef HOST_MEM_LOADER_VERIFY_EN
        // readback verify, clean then with one corrupted byte
        start_load(21'h300);
        send(4, 8'h21, 8'h10, 1'b1);
        wait_done("t6_clean");
        check("t6_clean_err", 64'(verify_err), 0);
        tick();
        corrupt_addr = 21'h302;
        corrupt = 1'b1;
        start_load(21'h300);
        send(4, 8'h21, 8'h10, 1'b1);
        wait_done("t6_bad");
        check("t6_bad_err", 64'(verify_err), 1);
        tick();
        check("t6_err_hold", 64'(verify_err), 1);
        corrupt = 1'b0;
        expect_write(21'h300, 8'h0F, 64'h0000000051413121);
        expect_write(21'h300, 8'h0F, 64'h0000000051413121);
        compare_writes("t6");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
